lstm_feature_sequencer: RTL

LSTM_FEATURE_SEQUENCER -- requirements
Module: lstm_feature_sequencer

---
 rtl/lstm_feature_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/lstm_feature_sequencer.sv
// lstm_feature_sequencer
// Streams one time step of feature words (INPUT_SIZE beats) from the feature
// memory to the LSTM core for each core request. After TIME_STEP steps it
// waits for the core's classification result.
// Build option: define LSTM_SEQ_TIMEOUT_EN to add a watchdog on the result wait.
module lstm_feature_sequencer #(
   parameter int unsigned INPUT_SIZE     = 26,
   parameter int unsigned TIME_STEP      = 148,
   parameter int unsigned D_WL           = 24,
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [D_WL-1:0]   mem_rd_data,
   input  logic              w_x_en,
   output logic              f_in_valid,
   output logic [D_WL-1:0]   feature_in,
   input  logic              o_valid,
   input  logic              result,
   output logic              busy,
   output logic              done,
   output logic              result_out,
   output logic [7:0]        frame_idx,
   output logic              overrun,
   output logic              timeout
);

   localparam int unsigned       BEAT_W    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(INPUT_SIZE - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(INPUT_SIZE * TIME_STEP - 1);
   localparam logic [7:0]        LAST_STEP = 8'(TIME_STEP - 1);

   // Reject parameter sets that the address, step or watchdog counters cannot hold.
   if ((INPUT_SIZE * TIME_STEP > (2 ** ADDR_W)) || (TIME_STEP > 255) ||
       (INPUT_SIZE == 0) || (TIMEOUT_CYCLES == 0)) begin : g_param_check
      $error("lstm_feature_sequencer: unsupported parameter combination");
   end

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REQ,
      STREAM,
      WAIT_RESULT,
      FINISH
   } state_t;

   state_t            state_q, state_d;
   logic              wx_q;
   logic              req;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [7:0]        frame_idx_q, frame_idx_d;
   logic              overrun_q, overrun_d;
   logic              result_out_q, result_out_d;
   logic              f_valid_q;
   logic              tmo_hit;

   // A request is a rising edge of w_x_en; a held level counts once.
   assign req = w_x_en & ~wx_q;

   // Next-state, address/beat counters and status flags; abort wins over everything.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beat_d       = beat_q;
      frame_idx_d  = frame_idx_q;
      overrun_d    = overrun_q;
      result_out_d = result_out_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d      = WAIT_REQ;
                  addr_d       = '0;
                  beat_d       = '0;
                  frame_idx_d  = '0;
                  overrun_d    = 1'b0;
                  result_out_d = 1'b0;
               end
            end
            WAIT_REQ: begin
               if (req) begin
                  state_d = STREAM;
                  beat_d  = '0;
               end
            end
            STREAM: begin
               if (req) overrun_d = 1'b1;
               // Address runs contiguously across steps and parks on the final word.
               if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  beat_d      = '0;
                  frame_idx_d = frame_idx_q + 8'd1;
                  state_d     = (frame_idx_q == LAST_STEP) ? WAIT_RESULT : WAIT_REQ;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
            WAIT_RESULT: begin
               if (req) overrun_d = 1'b1;
               if (o_valid) begin
                  state_d      = FINISH;
                  result_out_d = result;
               end else if (tmo_hit) begin
                  state_d      = FINISH;
                  result_out_d = 1'b0;
               end
            end
            FINISH: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wx_q         <= 1'b0;
         addr_q       <= '0;
         beat_q       <= '0;
         frame_idx_q  <= '0;
         overrun_q    <= 1'b0;
         result_out_q <= 1'b0;
         f_valid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wx_q         <= w_x_en;
         addr_q       <= addr_d;
         beat_q       <= beat_d;
         frame_idx_q  <= frame_idx_d;
         overrun_q    <= overrun_d;
         result_out_q <= result_out_d;
         f_valid_q    <= mem_rd_en & ~abort;
      end
   end

`ifdef LSTM_SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             timeout_q, timeout_d;

   assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Watchdog counts cycles spent in WAIT_RESULT; timeout is sticky until start.
   always_comb begin
      tmo_cnt_d = '0;
      timeout_d = timeout_q;
      if (!abort) begin
         if (state_q == WAIT_RESULT) tmo_cnt_d = tmo_cnt_q + 1'b1;
         if ((state_q == IDLE) && start) timeout_d = 1'b0;
         if ((state_q == WAIT_RESULT) && !o_valid && tmo_hit) timeout_d = 1'b1;
      end
   end

   // Watchdog registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   assign mem_rd_en  = (state_q == STREAM);
   assign mem_addr   = addr_q;
   assign f_in_valid = f_valid_q;
   // Memory data is only forwarded on valid beats so feature_in reads 0 otherwise.
   assign feature_in = f_valid_q ? mem_rd_data : '0;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FINISH);
   assign result_out = result_out_q;
   assign frame_idx  = frame_idx_q;
   assign overrun    = overrun_q;

endmodule
